// File: rtl/rol_iter.sv
// Iterative rotate-left: one bit position per enabled cycle, result held until taken.
// Latency: 1+ctrl enabled edges from accept to out_valid (ctrl=0 -> 1 edge).
// Backpressure: in_ready only in IDLE with en; result held in DONE until out_ready.
module rol_iter #(
    parameter int n = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [$clog2(n)-1:0]  ctrl,
    input  logic [n-1:0]          bits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [n-1:0]          out,
    output logic                  busy
);

    localparam int AW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cnt;
    logic [n-1:0]    data;
    logic            accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (ctrl == '0) ? DONE : ROT;
                end
            end
            ROT: begin
                if (cnt == AW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && en;
        out_valid = (state == DONE);
        busy      = (state == ROT);
    end

    // Datapath: operands are sampled only on the accept edge, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            data <= '0;
        end else if (en) begin
            if (accept) begin
                cnt  <= ctrl;
                data <= bits;
            end else if (state == ROT) begin
                cnt  <= cnt - AW'(1);
                data <= {data[n-2:0], data[n-1]};
            end
        end
    end

    assign out = data;

endmodule

// File: tb/tb_rol_iter.sv
// Directed bench for rol_iter (n=4) with hand-computed expectations.
module tb_rol_iter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ctrl;
    logic [3:0] bits;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rol_iter #(.n(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .bits      (bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rotr(input logic [3:0] v, input logic [1:0] s);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < int'(s); i++) r = {r[0], r[3:1]};
        return r;
    endfunction

    // Issue one request, scramble inputs afterwards, wait (bounded) for out_valid.
    task automatic do_op(input logic [3:0] b, input logic [1:0] c,
                         output logic [3:0] res, output int lat, output int bcyc);
        bits     = b;
        ctrl     = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bits     = ~b;
        ctrl     = ~c;
        lat  = 1;
        bcyc = 0;
        while (!out_valid && lat < 20) begin
            if (busy) bcyc++;
            tick();
            lat++;
        end
        res = out;
        tick();
    endtask

    logic [3:0] res;
    int         lat;
    int         bcyc;

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ctrl = 2'b00; bits = 4'b0000;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out",       32'(out),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        en = 1'b0;
        #1;
        check("rst_in_ready_en0", 32'(in_ready), 32'd0);
        en  = 1'b1;
        rst = 1'b0;
        tick();

        do_op(4'b1000, 2'b01, res, lat, bcyc);
        check("rol1_out",  32'(res), 32'b0001);
        check("rol1_lat",  32'(lat), 32'd2);
        check("rol1_busy", 32'(bcyc), 32'd1);
        check("rol1_idle_in_ready", 32'(in_ready), 32'd1);

        do_op(4'b1011, 2'b11, res, lat, bcyc);
        check("rol3_out", 32'(res), 32'b1101);
        check("rol3_lat", 32'(lat), 32'd4);

        do_op(4'b1011, 2'b00, res, lat, bcyc);
        check("rol0_out", 32'(res), 32'b1011);
        check("rol0_lat", 32'(lat), 32'd1);

        for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 4; c++) begin
                do_op(4'(b), 2'(c), res, lat, bcyc);
                check($sformatf("roundtrip_b%0d_c%0d", b, c), 32'(rotr(res, 2'(c))), 32'(b));
                check($sformatf("lat_b%0d_c%0d", b, c), 32'(lat), 32'(1 + c));
            end
        end

        // en=0 for 3 cycles while rotating
        bits = 4'b0110; ctrl = 2'b10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bits = 4'b0000;
        en = 1'b0;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
            check("en0_busy_hold", 32'(busy), 32'd1);
            check("en0_in_ready",  32'(in_ready), 32'd0);
        end
        en = 1'b1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("en0_lat", 32'(lat), 32'd6);
        check("en0_out", 32'(out), 32'b1001);
        tick();

        // hold result in DONE under backpressure
        out_ready = 1'b0;
        bits = 4'b1011; ctrl = 2'b00; in_valid = 1'b1;
        tick();
        in_valid = 1'b1;
        bits = 4'b0101; ctrl = 2'b01;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out",       32'(out),       32'b1011);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);

        // reset in the second rotate step
        bits = 4'b1011; ctrl = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_out",       32'(out),       32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_result", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rol_iter.md
ROL_ITER -- requirements
Module: rol_iter

Interface
REQ-001 The block SHALL have parameter n, default 4, giving the data width in bits; legal values are powers of two from 2 upward.
REQ-002 The block SHALL have local parameter AW = clog2(n), giving the rotate-amount width (2 when n=4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: global enable; 0 freezes all state.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the bits/ctrl request is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 The block SHALL have port ctrl, input, AW bits: the rotate-left amount (00 no change, 01 ROL#1, 10 ROL#2, 11 ROL#3 for n=4).
REQ-009 The block SHALL have port bits, input, n bits: the data to rotate.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out holds a completed result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out, output, n bits: the rotated result.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a rotation is in progress (ROT state).

Function
REQ-014 The block SHALL implement an FSM with exactly the states IDLE, ROT and DONE.
REQ-015 The block SHALL drive in_ready = (state==IDLE) && en, combinationally.
REQ-016 Accept: on the edge where in_valid && in_ready, the block SHALL capture bits into the data register and ctrl into the counter.
REQ-017 On accept with ctrl==0, the next state SHALL be DONE and the data SHALL be unchanged.
REQ-018 On accept with ctrl!=0, the next state SHALL be ROT.
REQ-019 In ROT with en=1, each edge SHALL rotate the data left by one (data <= {data[n-2:0], data[n-1]}) and decrement the counter by one.
REQ-020 In ROT, when the counter equals 1 at the edge, the next state SHALL be DONE.
REQ-021 Latency SHALL be 1+ctrl rising edges from the accept edge to out_valid=1 (1 cycle for ctrl=0, 4 cycles for ctrl=3).
REQ-022 Result: out SHALL equal bits rotated left by ctrl positions modulo n, i.e. the exact inverse of a rotate-right by ctrl.
REQ-023 The block SHALL drive out_valid = (state==DONE) and busy = (state==ROT).
REQ-024 The block SHALL drive out from the data register at all times; out is meaningful only while out_valid=1.
REQ-025 In DONE, the block SHALL hold out stable until out_ready=1 at an edge with en=1, then return to IDLE.
REQ-026 No new request SHALL be accepted in DONE or ROT (no overlap); in_ready is 0 in those states.
REQ-027 The block SHALL assert in_ready again no earlier than the cycle after the out handshake.
REQ-028 When en=0, all registers (state, counter, data) SHALL hold, in_ready SHALL be 0, and out_valid/out SHALL hold their current values.
REQ-029 A rotate amount of n-1 SHALL complete correctly; wrap-around of the MSB into the LSB SHALL be exact on every step.
REQ-030 Inputs bits and ctrl SHALL be ignored outside the accept edge; changes during ROT or DONE SHALL not affect the result.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL set state to IDLE, the counter to 0, and the data register to 0, regardless of en.
REQ-032 After reset the outputs SHALL be out_valid=0, busy=0, out=0, and in_ready=en.
REQ-033 Reset asserted mid-ROT or in DONE SHALL abort the operation with no further out_valid for that request.
REQ-034 rst SHALL take priority over en, in_valid and out_ready in the same cycle.

Verification
REQ-035 The bench SHALL cover: n=4, en=1, bits=4'b1000, ctrl=01, out_ready=1 -> out_valid after 2 cycles with out=4'b0001, busy high for 1 cycle.
REQ-036 The bench SHALL cover: bits=4'b1011, ctrl=11 -> out=4'b1101 after 4 cycles; bits=4'b1011, ctrl=00 -> out=4'b1011 after 1 cycle.
REQ-037 The bench SHALL cover: all 16 bits values x 4 ctrl values, with each result rotated right by ctrl -> the original bits (round-trip inverse check).
REQ-038 The bench SHALL cover: bits=4'b0110, ctrl=10 with en=0 for 3 cycles mid-ROT -> latency extends by 3 and out=4'b1001.
REQ-039 The bench SHALL cover: out_ready=0 for 5 cycles in DONE -> out_valid and out stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-040 The bench SHALL cover: rst=1 during ROT (ctrl=11, second step) -> next cycle state IDLE, out=0, out_valid=0, busy=0, and no result is produced.
